// File: rtl/isqrt_sequencer_if.sv
// Handshake bundle between the sequencer and a multi-cycle integer square-root core.
//   core_start : one-cycle start pulse (sequencer -> core)
//   core_x     : operand, held stable from the start pulse until core_done (sequencer -> core)
//   core_done  : one-cycle completion pulse (core -> sequencer)
//   core_y     : result, valid in the core_done cycle (core -> sequencer)
// Modports: master = sequencer side, slave = core side.
interface isqrt_sequencer_if #(
   parameter int W = 8
);
   logic             core_start;
   logic [W-1:0]     core_x;
   logic             core_done;
   logic [W/2-1:0]   core_y;

   modport master (
      output core_start,
      output core_x,
      input  core_done,
      input  core_y
   );

   modport slave (
      input  core_start,
      input  core_x,
      output core_done,
      output core_y
   );
endinterface

// File: rtl/isqrt_sequencer.sv
// Controller between board buttons/switches and a multi-cycle isqrt core.
// Conditions the raw buttons (2-flop sync + debounce + rising-edge event),
// captures the operand, issues start pulses, waits for done, and self-checks
// every result. Supports a single compute and a full sweep of all 2^W operands
// with a sticky error flag.
// Ports:
//   clock    : system clock
//   reset_n  : asynchronous active-low reset
//   buttons  : raw active-high buttons, [0] single, [1] sweep, [2] abort/clear
//   inputs   : operand switches, sampled on a single press only
//   outputs  : [3:0] last result y, [7:4] core_x[7:4] while sweeping else 0,
//              [8] error, [9] busy  (layout of the W=8 board example)
//   core     : master side of the core handshake (start/x out, done/y in)
module isqrt_sequencer #(
   parameter int W       = 8,
   parameter int DEB_W   = 20,
   parameter int TIMEOUT = 64
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [2:0]          buttons,
   input  logic [W-1:0]        inputs,
   output logic [9:0]          outputs,
   isqrt_sequencer_if.master   core
);

   localparam int H  = W / 2;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Button conditioning
   // ------------------------------------------------------------------
   logic [2:0] level;    // debounced, accepted level per button
   logic [2:0] press;    // one-cycle pulse on a rising edge of the accepted level

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_button
         logic             sync1_reg;
         logic             sync2_reg;
         logic             level_reg;
         logic             level_d_reg;
         logic [DEB_W-1:0] deb_cnt_reg;

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               sync1_reg   <= 1'b0;
               sync2_reg   <= 1'b0;
               level_reg   <= 1'b0;
               level_d_reg <= 1'b0;
               deb_cnt_reg <= '0;
            end else begin
               sync1_reg   <= buttons[gi];
               sync2_reg   <= sync1_reg;
               level_d_reg <= level_reg;
               // Any cycle where the synced level matches the accepted one
               // restarts the count, so a bouncing input never qualifies.
               if (sync2_reg == level_reg) begin
                  deb_cnt_reg <= '0;
               end else if (deb_cnt_reg == {DEB_W{1'b1}}) begin
                  level_reg   <= sync2_reg;
                  deb_cnt_reg <= '0;
               end else begin
                  deb_cnt_reg <= deb_cnt_reg + 1'b1;
               end
            end
         end

         assign level[gi] = level_reg;
         assign press[gi] = level_reg & ~level_d_reg;
      end
   endgenerate

   // Event priority: abort > single > sweep
   logic ev_abort;
   logic ev_single;
   logic ev_sweep;

   assign ev_abort  = press[2];
   assign ev_single = press[0] & ~press[2];
   assign ev_sweep  = press[1] & ~press[0] & ~press[2];

   // ------------------------------------------------------------------
   // Result check: y*y <= x < (y+1)*(y+1), evaluated in W+1 bits because
   // (y+1)^2 reaches 2^W for the largest y.
   // ------------------------------------------------------------------
   logic [W:0] x_ext;
   logic [W:0] y_ext;
   logic [W:0] y_inc;
   logic [W:0] sq_lo;
   logic [W:0] sq_hi;
   logic       check_pass;

   state_t         state_reg;
   state_t         state_next;
   logic [W-1:0]   core_x_reg;
   logic [W-1:0]   core_x_next;
   logic [H-1:0]   y_reg;
   logic [H-1:0]   y_next;
   logic           error_reg;
   logic           error_next;
   logic           sweep_reg;
   logic           sweep_next;
   logic [TW-1:0]  tmo_reg;
   logic [TW-1:0]  tmo_next;

   always_comb begin
      x_ext      = {1'b0, core_x_reg};
      y_ext      = {{(W + 1 - H){1'b0}}, core.core_y};
      y_inc      = y_ext + (W + 1)'(1);
      sq_lo      = y_ext * y_ext;
      sq_hi      = y_inc * y_inc;
      check_pass = (sq_lo <= x_ext) && (sq_hi > x_ext);
   end

   // ------------------------------------------------------------------
   // FSM: state and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         core_x_reg <= '0;
         y_reg      <= '0;
         error_reg  <= 1'b0;
         sweep_reg  <= 1'b0;
         tmo_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         core_x_reg <= core_x_next;
         y_reg      <= y_next;
         error_reg  <= error_next;
         sweep_reg  <= sweep_next;
         tmo_reg    <= tmo_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state and datapath updates
   // ------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      core_x_next = core_x_reg;
      y_next      = y_reg;
      error_next  = error_reg;
      sweep_next  = sweep_reg;
      tmo_next    = tmo_reg;

      case (state_reg)
         IDLE: begin
            if (ev_abort) begin
               error_next = 1'b0;
               sweep_next = 1'b0;
            end else if (ev_single) begin
               core_x_next = inputs;
               sweep_next  = 1'b0;
               state_next  = ISSUE;
            end else if (ev_sweep) begin
               core_x_next = '0;
               sweep_next  = 1'b1;
               error_next  = 1'b0;
               state_next  = ISSUE;
            end
         end

         ISSUE: begin
            tmo_next = '0;
            if (ev_abort) begin
               // The core already saw this start, so wait out its done.
               error_next = 1'b0;
               sweep_next = 1'b0;
               state_next = DRAIN;
            end else begin
               state_next = WAIT;
            end
         end

         WAIT: begin
            if (ev_abort) begin
               // Abort wins even over a same-cycle done; that result is dropped.
               error_next = 1'b0;
               sweep_next = 1'b0;
               tmo_next   = '0;
               state_next = DRAIN;
            end else if (core.core_done) begin
               y_next = core.core_y;
               if (!check_pass) begin
                  error_next = 1'b1;
               end
               if (sweep_reg && (core_x_reg != {W{1'b1}})) begin
                  core_x_next = core_x_reg + 1'b1;
                  state_next  = ISSUE;
               end else begin
                  // Sweep ends on the last operand without wrapping core_x.
                  sweep_next = 1'b0;
                  state_next = IDLE;
               end
            end else if (tmo_reg == TW'(TIMEOUT - 1)) begin
               error_next = 1'b1;
               sweep_next = 1'b0;
               state_next = IDLE;
            end else begin
               tmo_next = tmo_reg + 1'b1;
            end
         end

         DRAIN: begin
            if (ev_abort) begin
               error_next = 1'b0;
               sweep_next = 1'b0;
            end
            if (core.core_done || (tmo_reg == TW'(TIMEOUT - 1))) begin
               state_next = IDLE;
            end else begin
               tmo_next = tmo_reg + 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   logic busy;

   assign busy            = (state_reg != IDLE);
   assign core.core_start = (state_reg == ISSUE);
   assign core.core_x     = core_x_reg;

   always_comb begin
      outputs         = '0;
      outputs[H-1:0]  = y_reg;
      outputs[7:4]    = sweep_reg ? core_x_reg[7:4] : 4'd0;
      outputs[8]      = error_reg;
      outputs[9]      = busy;
   end

endmodule
